// File: rtl/bmr_loader_pkg.sv
// Shared types and constants for the glyph bitmap loader that feeds the match accelerator.
package bmr_loader_pkg;

  localparam int WORD_W      = 32;
  localparam int BMR_W       = 1536;
  localparam int NUM_WORDS   = BMR_W / WORD_W;
  localparam int ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FIRE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/bmr_shift_assembler.sv
// Word-serial shift register that assembles a wide bitmap, first word ending up in the MSBs.
// Also used by the debug dump path, so it keeps its own enable/clear interface.
module bmr_shift_assembler #(
  parameter int WORD_W = bmr_loader_pkg::WORD_W,
  parameter int BMR_W  = bmr_loader_pkg::BMR_W
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              shift_en_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [BMR_W-1:0]  bmr_o
);

  logic [BMR_W-1:0] bmr_q, bmr_d;

  always_comb begin
    bmr_d = bmr_q;
    if (clr_i) begin
      bmr_d = '0;
    end else if (shift_en_i) begin
      bmr_d = {bmr_q[BMR_W-WORD_W-1:0], word_i};
    end
  end

  // NOTE: this is a flop array, not a RAM, so a clear is legal; the accelerator
  // expects an all-zero bitmap after reset, which is why it is cleared at all.
  always_ff @(posedge clk) begin
    bmr_q <= bmr_d;
  end

  assign bmr_o = bmr_q;

endmodule

// File: rtl/bmr_loader.sv
// Fetches a glyph bitmap word by word, starts the match accelerator and latches its result.
// Optional watchdog on the accelerator wait is built when BMR_LOADER_TIMEOUT_EN is defined.
module bmr_loader #(
  parameter int WORD_W         = bmr_loader_pkg::WORD_W,
  parameter int BMR_W          = bmr_loader_pkg::BMR_W,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [BMR_W-1:0]  bmr,
  output logic              acc_start,
  input  logic              acc_finish,
  input  logic [15:0]       acc_note,
  input  logic [15:0]       acc_length,
  output logic [15:0]       note_out,
  output logic [15:0]       length_out
);
  import bmr_loader_pkg::*;

  localparam int WORDS = BMR_W / WORD_W;
  localparam int CNT_W = $clog2(WORDS + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [15:0]         note_q, note_d;
  logic [15:0]         len_q, len_d;
  logic                shift_en;
  logic                timeout_hit;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    len_d    = len_q;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_FETCH;
          addr_d  = base_addr;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (mem_valid) begin
          shift_en = 1'b1;
          addr_d   = addr_q + ADDR_W'(ADDR_STRIDE);
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) state_d = ST_FIRE;
        end
      end
      ST_FIRE:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (acc_finish) begin
          note_d  = acc_note;
          len_d   = acc_length;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        // A finish level still high from this run must not be seen as the next result.
        if (!acc_finish) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      len_q   <= len_d;
    end
  end

`ifdef BMR_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Held at zero outside WAIT, so it restarts from zero on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) tmo_q <= '0;
    else                           tmo_q <= tmo_q + TMO_W'(1);
  end

  assign timeout_hit = (state_q == ST_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err         = timeout_hit && !acc_finish;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  bmr_shift_assembler #(
    .WORD_W (WORD_W),
    .BMR_W  (BMR_W)
  ) u_asm (
    .clk        (clk),
    .clr_i      (rst),
    .shift_en_i (shift_en),
    .word_i     (mem_rdata),
    .bmr_o      (bmr)
  );

  assign busy       = (state_q != ST_IDLE);
  assign mem_req    = (state_q == ST_FETCH);
  assign mem_addr   = addr_q;
  assign acc_start  = (state_q == ST_FIRE);
  assign done       = (state_q == ST_DONE);
  assign note_out   = note_q;
  assign length_out = len_q;

endmodule

// File: tb/tb_bmr_loader.sv
// Bench for bmr_loader: randomised memory latency and accelerator behaviour against a word-level model.
`timescale 1ns/1ps
module tb_bmr_loader;
  import bmr_loader_pkg::*;

  localparam int AW  = 32;
  localparam int TMO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go  = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic              busy, done, err, mem_req, acc_start;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              mem_valid = 1'b0;
  logic [BMR_W-1:0]  bmr;
  logic              acc_finish = 1'b0;
  logic [15:0]       acc_note = '0, acc_length = '0;
  logic [15:0]       note_out, length_out;

  bmr_loader #(
    .WORD_W(WORD_W), .BMR_W(BMR_W), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .bmr(bmr), .acc_start(acc_start), .acc_finish(acc_finish),
    .acc_note(acc_note), .acc_length(acc_length),
    .note_out(note_out), .length_out(length_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor: samples 2 ns after each falling edge, once all bench drivers have settled.
  int cyc = 0;
  int start_cnt, done_cnt, err_cnt, req_cnt;
  int start_cyc, done_cyc, err_cyc, go_cyc;
  always @(negedge clk) begin
    #2;
    cyc++;
    if (acc_start === 1'b1) begin start_cnt++; start_cyc = cyc; end
    if (done === 1'b1)      begin done_cnt++;  done_cyc  = cyc; end
    if (err === 1'b1)       begin err_cnt++;   err_cyc   = cyc; end
    if (mem_req === 1'b1)   req_cnt++;
  end

  // Memory model: word i of a load is 0xA5000000|i, served after 0..max_delay cycles.
  int          max_delay = 0;
  logic [31:0] cur_base  = '0;
  int          words_seen = 0;
  bit          waiting = 0;
  int          wait_left = 0;
  logic [31:0] req_addr = '0;
  bit          stray_pulse = 0;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (!waiting) begin
        waiting   = 1;
        wait_left = $urandom_range(0, max_delay);
        req_addr  = mem_addr;
      end else begin
        total++;
        if (mem_addr !== req_addr) begin
          bad++;
          $display("FAIL addr_stable: mem_addr=%h required=%h", mem_addr, req_addr);
        end
      end
      if (wait_left == 0) begin
        total++;
        if (req_addr !== cur_base + 32'(4 * words_seen)) begin
          bad++;
          $display("FAIL addr_seq: word %0d mem_addr=%h required=%h", words_seen, req_addr,
                   cur_base + 32'(4 * words_seen));
        end
        mem_valid = 1'b1;
        mem_rdata = 32'hA500_0000 | 32'(words_seen);
        words_seen++;
        waiting = 0;
      end else begin
        mem_valid = 1'b0;
        wait_left--;
      end
    end else begin
      waiting   = 0;
      mem_valid = stray_pulse;
      mem_rdata = $urandom;
      stray_pulse = 0;
    end
  end

  // Accelerator model: registers start, raises finish acc_lat cycles later for acc_hold cycles.
  int acc_lat = 11, acc_hold = 1;
  bit acc_never = 0;
  int acc_cd = -1, acc_left = 0;
  always @(negedge clk) begin
    if (acc_left > 0) begin
      acc_left--;
      if (acc_left == 0) acc_finish = 1'b0;
    end
    if (acc_cd > 0) begin
      acc_cd--;
      if (acc_cd == 0) begin
        acc_cd = -1;
        acc_finish = 1'b1;
        acc_left = acc_hold;
      end
    end
    if (acc_start === 1'b1 && !acc_never) acc_cd = acc_lat;
  end

  function automatic logic [BMR_W-1:0] exp_bmr();
    logic [BMR_W-1:0] v = '0;
    for (int i = 0; i < NUM_WORDS; i++) v[BMR_W-1-WORD_W*i -: WORD_W] = 32'hA500_0000 | 32'(i);
    return v;
  endfunction

  task automatic start_load(input logic [31:0] base);
    @(negedge clk);
    cur_base = base; words_seen = 0;
    start_cnt = 0; done_cnt = 0; err_cnt = 0; req_cnt = 0;
    base_addr = base; go = 1'b1;
    #3 go_cyc = cyc;
    @(negedge clk);
    go = 1'b0; base_addr = $urandom;
    #3;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== base) begin
      bad++;
      $display("FAIL first_req: mem_req=%b mem_addr=%h required 1/%h", mem_req, mem_addr, base);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); #3; n++; end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget, output int idle_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); #3; n++; end
    idle_cyc = cyc;
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    total++;
    if ({busy, done, err, mem_req, acc_start} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy/done/err/req/start=%b required 00000",
               {busy, done, err, mem_req, acc_start});
    end
    total++;
    if (bmr !== '0 || mem_addr !== '0 || note_out !== '0 || length_out !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h note=%h len=%h bmr_top=%h required all 0",
               mem_addr, note_out, length_out, bmr[BMR_W-1 -: 32]);
    end
  endtask

  task automatic test_zero_wait();
    int idle_cyc;
    logic [15:0] nv = 16'($urandom), lv = 16'($urandom);
    acc_note = nv; acc_length = lv; max_delay = 0; acc_lat = 11; acc_hold = 1;
    start_load(32'h0000_1000);
    wait_done(200);
    total++;
    if (note_out !== nv || length_out !== lv) begin
      bad++;
      $display("FAIL zw_result: note=%h len=%h required %h/%h", note_out, length_out, nv, lv);
    end
    total++;
    if (req_cnt !== 48) begin bad++; $display("FAIL zw_req_cycles: got %0d required 48", req_cnt); end
    total++;
    if (start_cnt !== 1 || start_cyc !== go_cyc + 49) begin
      bad++;
      $display("FAIL zw_start: pulses=%0d at +%0d required 1 at +49", start_cnt, start_cyc - go_cyc);
    end
    total++;
    if (done_cyc !== start_cyc + 12) begin
      bad++;
      $display("FAIL zw_done_lat: done %0d cycles after start required 12", done_cyc - start_cyc);
    end
    total++;
    if (bmr[1535:1504] !== 32'hA500_0000 || bmr[31:0] !== 32'hA500_002F) begin
      bad++;
      $display("FAIL zw_bmr_ends: top=%h bottom=%h required a5000000/a500002f", bmr[1535:1504], bmr[31:0]);
    end
    wait_idle(50, idle_cyc);
    total++;
    if (bmr !== exp_bmr() || done_cnt !== 1) begin
      bad++;
      $display("FAIL zw_bmr_hold: bmr match=%0b done pulses=%0d required 1/1", bmr === exp_bmr(), done_cnt);
    end
  endtask

  task automatic test_random_wait();
    int idle_cyc;
    logic [31:0] bases [2];
    bases[0] = $urandom & 32'hFFFF_FFFC;
    bases[1] = 32'hFFFF_FFA0;
    max_delay = 5;
    for (int k = 0; k < 2; k++) begin
      logic [15:0] nv = 16'($urandom), lv = 16'($urandom);
      acc_note = nv; acc_length = lv;
      acc_lat = $urandom_range(1, 20); acc_hold = $urandom_range(1, 4);
      start_load(bases[k]);
      wait_done(800);
      total++;
      if (note_out !== nv || length_out !== lv) begin
        bad++;
        $display("FAIL rw_result%0d: note=%h len=%h required %h/%h", k, note_out, length_out, nv, lv);
      end
      wait_idle(50, idle_cyc);
      total++;
      if (bmr !== exp_bmr() || done_cnt !== 1 || start_cnt !== 1) begin
        bad++;
        $display("FAIL rw_bmr%0d: bmr match=%0b done=%0d start=%0d required 1/1/1", k,
                 bmr === exp_bmr(), done_cnt, start_cnt);
      end
    end
    max_delay = 0;
  endtask

  task automatic test_drain();
    int idle_cyc, req_before;
    acc_note = 16'h0009; acc_length = 16'h0004; acc_lat = 11; acc_hold = 5;
    start_load(32'h0000_2000);
    wait_done(200);
    total++;
    if (note_out !== 16'h0009 || length_out !== 16'h0004) begin
      bad++;
      $display("FAIL drain_result: note=%h len=%h required 0009/0004", note_out, length_out);
    end
    @(negedge clk);
    base_addr = 32'h0000_5000; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #3;
    wait_idle(50, idle_cyc);
    total++;
    if (idle_cyc !== done_cyc + 5 || acc_finish !== 1'b0) begin
      bad++;
      $display("FAIL drain_exit: busy fell %0d cycles after done (finish=%b) required 5 (0)",
               idle_cyc - done_cyc, acc_finish);
    end
    req_before = req_cnt;
    repeat (6) @(negedge clk);
    #3;
    total++;
    if (busy !== 1'b0 || req_cnt !== req_before || done_cnt !== 1) begin
      bad++;
      $display("FAIL drain_go_ignored: busy=%b extra req=%0d done=%0d required 0/0/1",
               busy, req_cnt - req_before, done_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n = 0;
    acc_lat = 11; acc_hold = 1;
    start_load(32'h0000_3000);
    while (words_seen < 20 && n < 200) begin @(negedge clk); #3; n++; end
    total++;
    if (words_seen < 20) begin bad++; $display("FAIL mid_wait: only %0d words", words_seen); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #3;
    total++;
    if ({busy, mem_req, acc_start, done, err} !== 5'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL mid_rst_ctrl: busy/req/start/done/err=%b addr=%h required 0", {busy, mem_req,
               acc_start, done, err}, mem_addr);
    end
    total++;
    if (bmr !== '0 || note_out !== '0 || length_out !== '0) begin
      bad++;
      $display("FAIL mid_rst_data: note=%h len=%h bmr_top=%h required 0", note_out, length_out,
               bmr[BMR_W-1 -: 32]);
    end
    stray_pulse = 1;
    repeat (3) @(negedge clk);
    #3;
    total++;
    if (bmr !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_valid: busy=%b bmr_low=%h required 0/0", busy, bmr[31:0]);
    end
    start_load(32'h0000_4000);
    wait_done(200);
    total++;
    if (bmr !== exp_bmr() || start_cyc !== go_cyc + 49) begin
      bad++;
      $display("FAIL restart: bmr match=%0b start at +%0d required 1/+49", bmr === exp_bmr(),
               start_cyc - go_cyc);
    end
  endtask

  task automatic test_timeout();
    int idle_cyc;
    logic [15:0] note_prev;
    repeat (4) @(negedge clk);
    note_prev = note_out;
    acc_never = 1;
    start_load(32'h0000_6000);
`ifdef BMR_LOADER_TIMEOUT_EN
    begin
      int n = 0;
      while (err_cnt == 0 && n < 300) begin @(negedge clk); #3; n++; end
    end
    total++;
    if (err_cnt !== 1 || err_cyc !== start_cyc + TMO) begin
      bad++;
      $display("FAIL tmo_err: pulses=%0d at +%0d required 1 at +%0d", err_cnt, err_cyc - start_cyc, TMO);
    end
    wait_idle(20, idle_cyc);
    total++;
    if (note_out !== note_prev || done_cnt !== 0 || err_cnt !== 1) begin
      bad++;
      $display("FAIL tmo_after: note=%h done=%0d err=%0d required %h/0/1", note_out, done_cnt,
               err_cnt, note_prev);
    end
`else
    repeat (300) @(negedge clk);
    #3;
    total++;
    if (busy !== 1'b1 || err_cnt !== 0 || done_cnt !== 0 || note_out !== note_prev) begin
      bad++;
      $display("FAIL no_tmo: busy=%b err=%0d done=%0d required 1/0/0", busy, err_cnt, done_cnt);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_idle(5, idle_cyc);
`endif
    acc_never = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_random_wait();
    test_drain();
    test_reset_mid_fetch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
